// File: rtl/cache_refill_ctrl_pkg.sv
// Shared definitions for the data-cache refill engine: geometry, table line
// layout, table write-type encodings and controller state encodings.
package cache_refill_ctrl_pkg;

  // Cache geometry (2-way, 256 sets, 16-byte lines)
  localparam int CR_TAG_W = 20;
  localparam int CR_IDX_W = 8;
  localparam int CR_OFF_W = 4;
  localparam int CR_BEATS = 4;
  localparam int BEAT_W   = 32;
  localparam int LINE_W   = CR_BEATS * BEAT_W;
  localparam int WAY_W    = CR_TAG_W + 2 + LINE_W;

  // Table write-type encodings
  localparam logic [1:0] W_NONE = 2'b00;
  localparam logic [1:0] W_PART = 2'b01;
  localparam logic [1:0] W_FULL = 2'b10;

  // Controller state encodings
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOOKUP = 3'd1;
  localparam logic [2:0] S_SELECT = 3'd2;
  localparam logic [2:0] S_WB     = 3'd3;
  localparam logic [2:0] S_RD_REQ = 3'd4;
  localparam logic [2:0] S_RD_RET = 3'd5;
  localparam logic [2:0] S_FILL   = 3'd6;
  localparam logic [2:0] S_DONE   = 3'd7;

  // One way of a table entry; member order fixes the bit positions:
  // tag[149:130], valid[129], dirty[128], data[127:0]
  typedef struct packed {
    logic [CR_TAG_W-1:0] tag;
    logic                valid;
    logic                dirty;
    logic [LINE_W-1:0]   data;
  } way_t;

  // Line-aligned byte address of a {tag, index} pair
  function automatic logic [31:0] line_addr(input logic [CR_TAG_W-1:0] tag,
                                            input logic [CR_IDX_W-1:0] idx);
    return {tag, idx, {CR_OFF_W{1'b0}}};
  endfunction

endpackage

// File: rtl/cache_refill_ctrl_victim_sel.sv
// Victim-way chooser: an invalid way is always preferred (way0 first);
// when both ways hold data a free-running LFSR bit breaks the tie.
module cache_refill_ctrl_victim_sel
  import cache_refill_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic way0_valid_i,
  input  logic way1_valid_i,
  output logic victim_o
);

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;
  logic       fb;

  // Fibonacci feedback from taps 8,6,5,4
  always_comb begin
    fb     = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
    lfsr_d = {lfsr_q[6:0], fb};
  end

  // LFSR advances every cycle once out of reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= 8'h01;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  // Invalid-first choice, pseudo-random when the set is full
  always_comb begin
    if (!way0_valid_i) begin
      victim_o = 1'b0;
    end else if (!way1_valid_i) begin
      victim_o = 1'b1;
    end else begin
      victim_o = lfsr_q[0];
    end
  end

endmodule

// File: rtl/cache_refill_ctrl.sv
// Miss-handling engine for the 2-way data cache: reads the set, picks a
// victim, writes it back when dirty, fetches the new line in 32-bit beats
// and installs it with one full-line table write.
module cache_refill_ctrl
  import cache_refill_ctrl_pkg::*;
#(
  parameter int TAG_W = CR_TAG_W,
  parameter int IDX_W = CR_IDX_W,
  parameter int OFF_W = CR_OFF_W,
  parameter int BEATS = CR_BEATS
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    miss_req_i,
  input  logic [31:0]                             miss_addr_i,
  output logic                                    busy_o,
  output logic                                    refill_done_o,
  output logic                                    tbl_req_o,
  output logic [IDX_W-1:0]                        tbl_r_index_o,
  input  logic [2*(TAG_W+2+BEATS*BEAT_W)-1:0]     tbl_r_data_i,
  output logic                                    tbl_way_o,
  output logic [IDX_W-1:0]                        tbl_w_index_o,
  output logic [1:0]                              tbl_w_type_o,
  output logic [TAG_W+2+BEATS*BEAT_W-1:0]         tbl_w_data_o,
  output logic                                    rd_req_o,
  output logic [31:0]                             rd_addr_o,
  input  logic                                    rd_rdy_i,
  input  logic                                    ret_valid_i,
  input  logic                                    ret_last_i,
  input  logic [BEAT_W-1:0]                       ret_data_i,
  output logic                                    wr_req_o,
  output logic [31:0]                             wr_addr_o,
  output logic [BEATS*BEAT_W-1:0]                 wr_data_o,
  input  logic                                    wr_rdy_i
);

  localparam int LW    = BEATS * BEAT_W;
  localparam int WW    = TAG_W + 2 + LW;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic [2:0]       state_q,  state_d;
  logic [TAG_W-1:0] tag_q,    tag_d;
  logic [IDX_W-1:0] idx_q,    idx_d;
  logic             victim_q, victim_d;
  logic [TAG_W-1:0] vtag_q,   vtag_d;
  logic [LW-1:0]    vdata_q,  vdata_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [LW-1:0]    line_q,   line_d;

  way_t way0;
  way_t way1;
  way_t way_v;
  way_t fill_word;
  logic sel_way;

  // Low address bits and the partial-write code have no role in a
  // full-line refill; they are collected here so nothing dangles.
  logic unused_ok;
  assign unused_ok = ^{miss_addr_i[OFF_W-1:0], W_PART};

  assign way0  = tbl_r_data_i[WW-1:0];
  assign way1  = tbl_r_data_i[2*WW-1:WW];
  assign way_v = sel_way ? way1 : way0;

  cache_refill_ctrl_victim_sel u_victim_sel (
    .clk          (clk),
    .rst_n        (rst_n),
    .way0_valid_i (way0.valid),
    .way1_valid_i (way1.valid),
    .victim_o     (sel_way)
  );

  // Next-state and datapath capture for the refill sequence
  always_comb begin
    state_d  = state_q;
    tag_d    = tag_q;
    idx_d    = idx_q;
    victim_d = victim_q;
    vtag_d   = vtag_q;
    vdata_d  = vdata_q;
    cnt_d    = cnt_q;
    line_d   = line_q;
    case (state_q)
      S_IDLE: begin
        if (miss_req_i) begin
          tag_d   = miss_addr_i[31 -: TAG_W];
          idx_d   = miss_addr_i[OFF_W +: IDX_W];
          line_d  = '0;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        state_d = S_SELECT;
      end
      S_SELECT: begin
        // Table data for the set is valid this cycle
        victim_d = sel_way;
        vtag_d   = way_v.tag;
        vdata_d  = way_v.data;
        state_d  = (way_v.valid && way_v.dirty) ? S_WB : S_RD_REQ;
      end
      S_WB: begin
        if (wr_rdy_i) begin
          state_d = S_RD_REQ;
        end
      end
      S_RD_REQ: begin
        cnt_d = '0;
        if (rd_rdy_i) begin
          state_d = S_RD_RET;
        end
      end
      S_RD_RET: begin
        if (ret_valid_i) begin
          // Counter wraps, so surplus beats overwrite earlier words
          for (int i = 0; i < BEATS; i++) begin
            if (cnt_q == i[CNT_W-1:0]) begin
              line_d[i*BEAT_W +: BEAT_W] = ret_data_i;
            end
          end
          cnt_d = cnt_q + 1'b1;
          if (ret_last_i) begin
            state_d = S_FILL;
          end
        end
      end
      S_FILL: begin
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and captured miss/victim context; reset abandons any refill
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      tag_q    <= '0;
      idx_q    <= '0;
      victim_q <= 1'b0;
      vtag_q   <= '0;
      vdata_q  <= '0;
      cnt_q    <= '0;
      line_q   <= '0;
    end else begin
      state_q  <= state_d;
      tag_q    <= tag_d;
      idx_q    <= idx_d;
      victim_q <= victim_d;
      vtag_q   <= vtag_d;
      vdata_q  <= vdata_d;
      cnt_q    <= cnt_d;
      line_q   <= line_d;
    end
  end

  // Installed line is always valid and clean
  always_comb begin
    fill_word       = '0;
    fill_word.tag   = tag_q;
    fill_word.valid = 1'b1;
    fill_word.dirty = 1'b0;
    fill_word.data  = line_q;
  end

  // Outputs decode straight from state so reset clears them at once
  assign busy_o        = (state_q != S_IDLE);
  assign refill_done_o = (state_q == S_DONE);
  assign tbl_req_o     = (state_q == S_LOOKUP) || (state_q == S_FILL);
  assign tbl_r_index_o = (state_q == S_LOOKUP) ? idx_q : '0;
  assign tbl_way_o     = (state_q == S_FILL) ? victim_q : 1'b0;
  assign tbl_w_index_o = (state_q == S_FILL) ? idx_q : '0;
  assign tbl_w_type_o  = (state_q == S_FILL) ? W_FULL : W_NONE;
  assign tbl_w_data_o  = (state_q == S_FILL) ? fill_word : '0;
  assign rd_req_o      = (state_q == S_RD_REQ);
  assign rd_addr_o     = (state_q == S_RD_REQ) ? line_addr(tag_q, idx_q) : 32'h0;
  assign wr_req_o      = (state_q == S_WB);
  assign wr_addr_o     = (state_q == S_WB) ? line_addr(vtag_q, idx_q) : 32'h0;
  assign wr_data_o     = (state_q == S_WB) ? vdata_q : '0;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Self-checking bench for cache_refill_ctrl: scoreboard queues of expected
// write-backs, line reads and table fills, popped when the DUT hands them off.
module tb_cache_refill_ctrl;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         miss_req_i;
  logic [31:0]  miss_addr_i;
  logic         busy_o;
  logic         refill_done_o;
  logic         tbl_req_o;
  logic [7:0]   tbl_r_index_o;
  logic [299:0] tbl_r_data_i;
  logic         tbl_way_o;
  logic [7:0]   tbl_w_index_o;
  logic [1:0]   tbl_w_type_o;
  logic [149:0] tbl_w_data_o;
  logic         rd_req_o;
  logic [31:0]  rd_addr_o;
  logic         rd_rdy_i;
  logic         ret_valid_i;
  logic         ret_last_i;
  logic [31:0]  ret_data_i;
  logic         wr_req_o;
  logic [31:0]  wr_addr_o;
  logic [127:0] wr_data_o;
  logic         wr_rdy_i;

  cache_refill_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .miss_req_i    (miss_req_i),
    .miss_addr_i   (miss_addr_i),
    .busy_o        (busy_o),
    .refill_done_o (refill_done_o),
    .tbl_req_o     (tbl_req_o),
    .tbl_r_index_o (tbl_r_index_o),
    .tbl_r_data_i  (tbl_r_data_i),
    .tbl_way_o     (tbl_way_o),
    .tbl_w_index_o (tbl_w_index_o),
    .tbl_w_type_o  (tbl_w_type_o),
    .tbl_w_data_o  (tbl_w_data_o),
    .rd_req_o      (rd_req_o),
    .rd_addr_o     (rd_addr_o),
    .rd_rdy_i      (rd_rdy_i),
    .ret_valid_i   (ret_valid_i),
    .ret_last_i    (ret_last_i),
    .ret_data_i    (ret_data_i),
    .wr_req_o      (wr_req_o),
    .wr_addr_o     (wr_addr_o),
    .wr_data_o     (wr_data_o),
    .wr_rdy_i      (wr_rdy_i)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard queues
  logic [159:0] exp_wr_q[$];
  logic [159:0] exp_rd_q[$];
  logic [159:0] exp_fill_q[$];

  int         cyc = 0;
  int         miss_cyc = 0;
  int         done_cyc = 0;
  int         done_cnt = 0;
  int         fill_cnt = 0;
  int         wr_seen = 0;
  logic [7:0] cur_idx = 8'h00;
  logic       sel_next = 1'b0;
  logic       sel_bit = 1'b0;
  logic [7:0] m_lfsr;

  always @(posedge clk) cyc++;

  // Reference tie-break LFSR: taps 8,6,5,4, seed 8'h01
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= 8'h01;
    else        m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  function automatic logic [149:0] mk_way(input logic [19:0] t, input logic v, input logic d,
                                          input logic [127:0] data);
    return {t, v, d, data};
  endfunction

  function automatic logic [159:0] fill_exp(input logic w, input logic [7:0] idx,
                                            input logic [19:0] t, input logic [127:0] ln);
    return {1'b0, w, idx, t, 1'b1, 1'b0, ln};
  endfunction

  // Monitor: pops the scoreboard on every hand-off
  always @(negedge clk) begin
    if (!rst_n) begin
      sel_next = 1'b0;
    end else begin
      if (sel_next) begin
        sel_bit  = m_lfsr[0];
        sel_next = 1'b0;
      end
      if (tbl_req_o && tbl_w_type_o == 2'b00) begin
        check_val("lookup_idx", 160'(tbl_r_index_o), 160'(cur_idx));
        sel_next = 1'b1;
      end
      if (wr_req_o) wr_seen++;
      if (wr_req_o && wr_rdy_i) begin
        if (exp_wr_q.size() == 0) check_val("wr_unexpected", 160'd1, 160'd0);
        else check_val("wr_xfer", {wr_addr_o, wr_data_o}, exp_wr_q.pop_front());
      end
      if (rd_req_o && rd_rdy_i) begin
        if (exp_rd_q.size() == 0) check_val("rd_unexpected", 160'd1, 160'd0);
        else check_val("rd_addr", 160'(rd_addr_o), exp_rd_q.pop_front());
      end
      if (tbl_w_type_o != 2'b00) begin
        fill_cnt++;
        if (exp_fill_q.size() == 0) check_val("fill_unexpected", 160'(tbl_w_type_o), 160'd0);
        else begin
          check_val("fill_type", 160'(tbl_w_type_o), 160'd2);
          check_val("fill_word", {1'b0, tbl_way_o, tbl_w_index_o, tbl_w_data_o}, exp_fill_q.pop_front());
        end
      end
      if (refill_done_o) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_miss(input logic [31:0] a);
    tick();
    miss_req_i  = 1'b1;
    miss_addr_i = a;
    miss_cyc    = cyc;
    cur_idx     = a[11:4];
    tick();
    miss_req_i  = 1'b0;
  endtask

  // Accept the line read after `delay` stalled cycles, then return 4 beats
  // separated by `gap` idle cycles
  task automatic do_read(input int delay, input int gap, input logic [127:0] ln);
    int n;
    logic [31:0] a0;
    rd_rdy_i = (delay == 0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rd_req_o && n < 60);
    if (!rd_req_o) begin
      check_val("rd_req_timeout", 160'd0, 160'd1);
      return;
    end
    a0 = rd_addr_o;
    for (int i = 0; i < delay; i++) begin
      tick();
      if (i == delay - 1) rd_rdy_i = 1'b1;
      @(negedge clk);
      check_val("rd_hold_req", 160'(rd_req_o), 160'd1);
      check_val("rd_hold_addr", 160'(rd_addr_o), 160'(a0));
    end
    for (int b = 0; b < 4; b++) begin
      tick();
      rd_rdy_i    = 1'b0;
      ret_valid_i = 1'b1;
      ret_last_i  = (b == 3);
      ret_data_i  = ln[32*b +: 32];
      if (b < 3) begin
        for (int g = 0; g < gap; g++) begin
          tick();
          ret_valid_i = 1'b0;
        end
      end
    end
    tick();
    ret_valid_i = 1'b0;
    ret_last_i  = 1'b0;
  endtask

  task automatic wait_done(input int prev, input string tag);
    int n = 0;
    while (done_cnt == prev && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_val(tag, 160'(done_cnt - prev), 160'd1);
  endtask

  logic [127:0] ln;
  logic [127:0] d0_data, d1_data;
  logic [31:0]  wa0;
  logic [127:0] wd0;
  int           dref, fref, wref, n;

  initial begin
    miss_req_i = 0; miss_addr_i = 0; tbl_r_data_i = '0;
    rd_rdy_i = 0; ret_valid_i = 0; ret_last_i = 0; ret_data_i = 0; wr_rdy_i = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_busy",   160'(busy_o), 160'd0);
    check_val("rst_tblreq", 160'(tbl_req_o), 160'd0);
    check_val("rst_wtype",  160'(tbl_w_type_o), 160'd0);
    check_val("rst_rdreq",  160'(rd_req_o), 160'd0);
    check_val("rst_wrreq",  160'(wr_req_o), 160'd0);
    check_val("rst_done",   160'(refill_done_o), 160'd0);
    tick();
    rst_n = 1'b1;
    repeat (2) tick();

    // T1: both ways invalid, minimum latency
    ln = 128'h00000044_00000033_00000022_00000011;
    tbl_r_data_i = '0;
    exp_rd_q.push_back(160'h12345670);
    exp_fill_q.push_back(fill_exp(1'b0, 8'h67, 20'h12345, ln));
    dref = done_cnt;
    do_miss(32'h1234_5670);
    @(negedge clk);
    check_val("t1_busy", 160'(busy_o), 160'd1);
    do_read(0, 0, ln);
    wait_done(dref, "t1_done");
    check_val("t1_latency", 160'(done_cyc - miss_cyc), 160'd9);
    check_val("t1_fill_left", 160'(exp_fill_q.size()), 160'd0);
    repeat (2) tick();

    // T2: way0 valid clean, way1 invalid -> way1, no write-back
    ln = 128'hCAFE0004_CAFE0003_CAFE0002_CAFE0001;
    tbl_r_data_i = {mk_way(20'h0, 1'b0, 1'b0, 128'h0),
                    mk_way(20'h0F0F0, 1'b1, 1'b0, 128'hDEAD_BEEF)};
    exp_rd_q.push_back(160'h22222B10);
    exp_fill_q.push_back(fill_exp(1'b1, 8'hB1, 20'h22222, ln));
    dref = done_cnt;
    wref = wr_seen;
    do_miss(32'h2222_2B10);
    do_read(0, 0, ln);
    wait_done(dref, "t2_done");
    check_val("t2_no_wr", 160'(wr_seen - wref), 160'd0);
    repeat (2) tick();

    // T3: both valid and dirty, wr_rdy late, stray miss_req during WB
    ln = 128'h0000000D_0000000C_0000000B_0000000A;
    d0_data = 128'h00000000_11111111_22222222_33333333;
    d1_data = 128'h44444444_55555555_66666666_77777777;
    tbl_r_data_i = {mk_way(20'hABCDE, 1'b1, 1'b1, d1_data),
                    mk_way(20'hABCDE, 1'b1, 1'b1, d0_data)};
    wr_rdy_i = 1'b0;
    exp_rd_q.push_back(160'h55555670);
    dref = done_cnt;
    do_miss(32'h5555_5670);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!wr_req_o && n < 20);
    check_val("t3_wr_req", 160'(wr_req_o), 160'd1);
    exp_wr_q.push_back({32'hABCD_E670, sel_bit ? d1_data : d0_data});
    exp_fill_q.push_back(fill_exp(sel_bit, 8'h67, 20'h55555, ln));
    wa0 = wr_addr_o;
    wd0 = wr_data_o;
    check_val("t3_wr_addr0", 160'(wa0), 160'hABCDE670);
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i == 0) begin
        miss_req_i  = 1'b1;
        miss_addr_i = 32'h7777_7770;
      end else begin
        miss_req_i = 1'b0;
      end
      if (i == 2) wr_rdy_i = 1'b1;
      @(negedge clk);
      check_val("t3_wr_hold", 160'(wr_req_o), 160'd1);
      check_val("t3_wr_addr", 160'(wr_addr_o), 160'(wa0));
      check_val("t3_wr_data", 160'(wr_data_o), 160'(wd0));
    end
    tick();
    wr_rdy_i = 1'b0;
    do_read(0, 0, ln);
    wait_done(dref, "t3_done");
    repeat (6) tick();
    @(negedge clk);
    check_val("t3_one_done", 160'(done_cnt - dref), 160'd1);
    check_val("t3_idle", 160'(busy_o), 160'd0);

    // T4: read accept stalled 5 cycles, gaps between beats
    ln = 128'h89ABCDEF_01234567_F0F0F0F0_0A0B0C0D;
    tbl_r_data_i = '0;
    exp_rd_q.push_back(160'h00001A30);
    exp_fill_q.push_back(fill_exp(1'b0, 8'hA3, 20'h00001, ln));
    dref = done_cnt;
    fref = fill_cnt;
    do_miss(32'h0000_1A30);
    do_read(5, 2, ln);
    wait_done(dref, "t4_done");
    check_val("t4_one_fill", 160'(fill_cnt - fref), 160'd1);
    repeat (2) tick();

    // T5: reset dropped mid-return, then a normal miss
    tbl_r_data_i = '0;
    exp_rd_q.push_back(160'h33333450);
    dref = done_cnt;
    fref = fill_cnt;
    rd_rdy_i = 1'b1;
    do_miss(32'h3333_3450);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rd_req_o && n < 20);
    check_val("t5_rd_req", 160'(rd_req_o), 160'd1);
    tick();
    rd_rdy_i = 1'b0;
    ret_valid_i = 1'b1; ret_data_i = 32'hAAAA_0001;
    tick();
    ret_data_i = 32'hAAAA_0002;
    #2 rst_n = 1'b0;
    #1;
    check_val("t5_busy",   160'(busy_o), 160'd0);
    check_val("t5_tblreq", 160'(tbl_req_o), 160'd0);
    check_val("t5_wtype",  160'(tbl_w_type_o), 160'd0);
    check_val("t5_wdata",  160'(tbl_w_data_o), 160'd0);
    check_val("t5_rdreq",  160'(rd_req_o), 160'd0);
    ret_valid_i = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (8) tick();
    check_val("t5_no_fill", 160'(fill_cnt - fref), 160'd0);
    check_val("t5_no_done", 160'(done_cnt - dref), 160'd0);
    ln = 128'h00000004_00000003_00000002_00000001;
    exp_rd_q.push_back(160'h44444560);
    exp_fill_q.push_back(fill_exp(1'b0, 8'h56, 20'h44444, ln));
    dref = done_cnt;
    do_miss(32'h4444_4560);
    do_read(0, 0, ln);
    wait_done(dref, "t5_after_rst_done");
    check_val("t5_latency", 160'(done_cyc - miss_cyc), 160'd9);

    repeat (3) tick();
    check_val("end_wr_q",   160'(exp_wr_q.size()), 160'd0);
    check_val("end_rd_q",   160'(exp_rd_q.size()), 160'd0);
    check_val("end_fill_q", 160'(exp_fill_q.size()), 160'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cache_refill_ctrl.md
Name: cache_refill_ctrl

Overview:
- Miss-handling engine for the 2-way data cache (20-bit tag, 8-bit index, 4-bit offset, 128-bit line).
- On a miss: reads both ways of the set from the cache table and picks a victim. Writes back the victim if it is dirty, then fetches a 4-beat line from memory and installs it with a full-line write.
- Drives the cache table's request/read/write port and consumes its 300-bit read output.

Parameters:
- TAG_W, 20, tag width
- IDX_W, 8, set index width
- OFF_W, 4, block offset width
- BEATS, 4, 32-bit return beats per line

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- miss_req_i  in  1  miss request from lookup stage; sampled only in IDLE
- miss_addr_i  in  32  miss physical address
- busy_o  out  1  high in every state except IDLE
- refill_done_o  out  1  one-cycle pulse when the line is installed
- tbl_req_o  out  1  cache table request
- tbl_r_index_o  out  8  table read index
- tbl_r_data_i  in  300  table read data, {way1[149:0],way0[149:0]}
- tbl_way_o  out  1  write way
- tbl_w_index_o  out  8  write index
- tbl_w_type_o  out  2  10 = full write, 00 = none
- tbl_w_data_o  out  150  {tag[149:130],valid[129],dirty[128],data[127:0]}
- rd_req_o  out  1  memory line read request
- rd_addr_o  out  32  line-aligned read address
- rd_rdy_i  in  1  read request accepted
- ret_valid_i  in  1  return beat valid
- ret_last_i  in  1  final return beat
- ret_data_i  in  32  return beat data
- wr_req_o  out  1  memory line write request
- wr_addr_o  out  32  line-aligned write address
- wr_data_o  out  128  victim line data
- wr_rdy_i  in  1  write request accepted

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; all outputs 0; LFSR=8'h01.
  - Reset mid-operation abandons the refill. No table write and no done pulse are issued.
- LFSR:
  - 8-bit Fibonacci LFSR, taps 8,6,5,4; advances every cycle after reset.
- IDLE:
  - On miss_req_i=1, latch addr and go to LOOKUP.
  - The tag field is addr[31:12]; the index is addr[11:4].
- LOOKUP (1 cycle):
  - tbl_req_o=1, tbl_w_type_o=00, tbl_r_index_o=latched index.
  - The table returns data the next cycle.
- SELECT (1 cycle):
  - Capture tbl_r_data_i.
  - Victim choice, in priority order: way0 invalid → way0; else way1 invalid → way1; else LFSR[0].
  - Victim valid&dirty → WB; otherwise → RD_REQ.
- WB:
  - wr_req_o=1, wr_addr_o={victim tag,index,4'h0}, wr_data_o=victim data.
  - Hold until wr_rdy_i=1 (the request is accepted in that cycle), then → RD_REQ.
- RD_REQ:
  - rd_req_o=1, rd_addr_o={miss tag,index,4'h0}.
  - Hold all fields stable until rd_rdy_i=1, then → RD_RET.
- RD_RET:
  - A 2-bit beat counter starts at 0; each ret_valid_i writes ret_data_i into word[cnt] (word0 = bits[31:0]) and increments.
  - ret_valid_i&ret_last_i → FILL.
  - Words never received are 0; beats after the counter wraps overwrite earlier words.
- FILL (1 cycle):
  - tbl_req_o=1, tbl_way_o=victim, tbl_w_index_o=index, tbl_w_type_o=10.
  - tbl_w_data_o={miss tag,1'b1,1'b0,line}.
  - Next state DONE.
- DONE (1 cycle):
  - refill_done_o=1, then → IDLE.
- General rules:
  - miss_req_i outside IDLE is ignored.
  - Minimum clean-miss latency from miss_req_i to refill_done_o, with rd_rdy_i immediate and 4 back-to-back beats: 9 cycles.
  - tbl_w_type_o is 00 in every state except FILL.

Decomposition:
- Shared define file: TAG/IDX/OFF widths, line field bit positions (tag/valid/dirty/data), w_type encodings (NONE=00, PART=01, FULL=10), state encodings.
- One natural sub-module: cache_victim_sel. It contains the LFSR plus the invalid-first victim choice, and outputs the victim way.

Test Plan:
- Both ways invalid, miss addr 0x1234_5670, beats 0x11,0x22,0x33,0x44:
  - rd_addr 0x1234_5670; FILL way0, index 0x67.
  - w_data = {20'h12345,1,0,128'h00000044_00000033_00000022_00000011}.
  - refill_done 9 cycles after miss_req.
- Way0 valid clean, way1 invalid → FILL targets way1; wr_req_o never asserted.
- Both valid, victim dirty with tag 0xABCDE at index 0x67, wr_rdy delayed 3 cycles:
  - wr_req held with wr_addr 0xABCD_E670 and victim data stable for 4 cycles, then rd_req issued.
- rd_rdy_i low 5 cycles, then ret_valid gaps between beats:
  - rd_req/addr stable throughout; line assembled correctly; exactly one FILL write.
- rst_n dropped during RD_RET:
  - Outputs go 0 immediately; no table write; next miss_req is accepted normally.
- miss_req_i pulsed during WB: ignored; exactly one refill_done per accepted miss.
